jtag_bitbang_sched: RTL and testbench

- Shares one set of JTAG pins between two bit-bang command sources: port 0 is the DPI remote-bit-bang host side, port 1 is a local on-chip sequencer.
- Arbitrates between the two sources with a transaction lock, buffers accepted commands in a tagged FIFO, and executes them in order.
- Paces TCK with a programmable hold time and returns sampled TDO to the requester that asked for it.
- Sits between the command sources and the TAP pins.

---
 rtl/jtag_bitbang_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_jtag_bitbang_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/jtag_bitbang_sched.sv
// jtag_bitbang_sched: two-source JTAG bit-bang arbiter, tagged FIFO and paced executor.
// Optional statistics counters are enabled with `define JTAG_SCHED_STATS_EN.
module jtag_bitbang_sched #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [4:0] req0_cmd_i,
    input  logic       req0_lock_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [4:0] req1_cmd_i,
    input  logic       req1_lock_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       rsp_tdo_o,
    output logic       rsp_id_o,
    output logic       jtag_tck_o,
    output logic       jtag_tms_o,
    output logic       jtag_tdi_o,
    output logic       jtag_trst_o,
    output logic       jtag_srst_o,
    output logic       blink_o,
    input  logic       jtag_tdo_i,
    output logic [1:0] owner_o
`ifdef JTAG_SCHED_STATS_EN
    ,
    output logic [15:0] tck_rise_cnt_o,
    output logic [7:0]  grant_switch_cnt_o
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {A_IDLE = 2'b00, A_OWN0 = 2'b01, A_OWN1 = 2'b10} arb_e;
    typedef enum logic [1:0] {X_EXEC, X_HOLD, X_RSP} exe_e;

    arb_e            arb_q, arb_d;
    logic            rr_q, rr_d;
    exe_e            exe_q, exe_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [5:0]      mem_q [FIFO_DEPTH];
    logic [5:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      pins_q, pins_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_tdo_q, rsp_tdo_d;
    logic            rsp_id_q, rsp_id_d;

    logic            full, push, pop, push_id;
    logic [4:0]      push_cmd;
    logic [5:0]      head;
    logic [1:0]      op;
    logic [2:0]      dat;

    assign full = (cnt_q == CW'(FIFO_DEPTH));
    assign head = mem_q[rd_q];
    assign op   = head[4:3];
    assign dat  = head[2:0];

    // Arbiter: grant from IDLE, accept from the owner, release when idle and unlocked.
    always_comb begin
        arb_d        = arb_q;
        rr_d         = rr_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        push         = 1'b0;
        push_id      = 1'b0;
        push_cmd     = req0_cmd_i;
        unique case (arb_q)
            A_IDLE: begin
                if (req0_valid_i && req1_valid_i) begin
                    arb_d = rr_q ? A_OWN1 : A_OWN0;
                end else if (req0_valid_i) begin
                    arb_d = A_OWN0;
                end else if (req1_valid_i) begin
                    arb_d = A_OWN1;
                end
            end
            A_OWN0: begin
                req0_ready_o = !full;
                push         = req0_valid_i && !full;
                if (!req0_valid_i && !req0_lock_i) begin
                    arb_d = A_IDLE;
                    rr_d  = 1'b1;
                end
            end
            A_OWN1: begin
                req1_ready_o = !full;
                push         = req1_valid_i && !full;
                push_id      = 1'b1;
                push_cmd     = req1_cmd_i;
                if (!req1_valid_i && !req1_lock_i) begin
                    arb_d = A_IDLE;
                    rr_d  = 1'b0;
                end
            end
            default: arb_d = A_IDLE;
        endcase
    end

    // FIFO bookkeeping: entries carry the requester id alongside the command.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = {push_id, push_cmd};
            wr_d        = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // Executor: pop and apply commands, pace WRITEs, hold READ responses.
    always_comb begin
        exe_d       = exe_q;
        hold_d      = hold_q;
        pins_d      = pins_q;
        rsp_valid_d = rsp_valid_q;
        rsp_tdo_d   = rsp_tdo_q;
        rsp_id_d    = rsp_id_q;
        pop         = 1'b0;
        unique case (exe_q)
            X_EXEC: begin
                if (enable_i && cnt_q != '0) begin
                    pop = 1'b1;
                    unique case (op)
                        2'b00: begin
                            pins_d[5:3] = dat;
                            hold_d      = HOLD_LD;
                            if (HOLD_CYCLES != 0) begin
                                exe_d = X_HOLD;
                            end
                        end
                        2'b01: pins_d[2:1] = dat[1:0];
                        2'b10: pins_d[0] = dat[0];
                        2'b11: begin
                            rsp_valid_d = 1'b1;
                            rsp_tdo_d   = jtag_tdo_i;
                            rsp_id_d    = head[5];
                            exe_d       = X_RSP;
                        end
                    endcase
                end
            end
            X_HOLD: begin
                if (enable_i) begin
                    if (hold_q <= HW'(1)) begin
                        hold_d = '0;
                        exe_d  = X_EXEC;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            X_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    exe_d       = X_EXEC;
                end
            end
            default: exe_d = X_EXEC;
        endcase
    end

    // State, FIFO and pin registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_q       <= A_IDLE;
            rr_q        <= 1'b0;
            exe_q       <= X_EXEC;
            hold_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            pins_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tdo_q   <= 1'b0;
            rsp_id_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            arb_q       <= arb_d;
            rr_q        <= rr_d;
            exe_q       <= exe_d;
            hold_q      <= hold_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            pins_q      <= pins_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tdo_q   <= rsp_tdo_d;
            rsp_id_q    <= rsp_id_d;
            mem_q       <= mem_d;
        end
    end

    assign owner_o     = arb_q;
    assign jtag_tck_o  = pins_q[5];
    assign jtag_tms_o  = pins_q[4];
    assign jtag_tdi_o  = pins_q[3];
    assign jtag_trst_o = pins_q[2];
    assign jtag_srst_o = pins_q[1];
    assign blink_o     = pins_q[0];
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_tdo_o   = rsp_tdo_q;
    assign rsp_id_o    = rsp_id_q;

`ifdef JTAG_SCHED_STATS_EN
    logic [15:0] tck_rise_q, tck_rise_d;
    logic [7:0]  gsw_q, gsw_d;
    logic [1:0]  prev_own_q, prev_own_d;

    // Saturating TCK-rise and owner-switch counters.
    always_comb begin
        tck_rise_d = tck_rise_q;
        gsw_d      = gsw_q;
        prev_own_d = prev_own_q;
        if (pop && op == 2'b00 && dat[2] && !pins_q[5] && tck_rise_q != 16'hFFFF) begin
            tck_rise_d = tck_rise_q + 16'd1;
        end
        if (arb_q == A_IDLE && arb_d != A_IDLE) begin
            prev_own_d = arb_d;
            if (arb_d != prev_own_q && gsw_q != 8'hFF) begin
                gsw_d = gsw_q + 8'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_rise_q <= '0;
            gsw_q      <= '0;
            prev_own_q <= '0;
        end else begin
            tck_rise_q <= tck_rise_d;
            gsw_q      <= gsw_d;
            prev_own_q <= prev_own_d;
        end
    end

    assign tck_rise_cnt_o     = tck_rise_q;
    assign grant_switch_cnt_o = gsw_q;
`endif

endmodule

// File: tb/tb_jtag_bitbang_sched.sv
// tb_jtag_bitbang_sched: directed test of arbitration, pacing, responses and reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_jtag_bitbang_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       v0, r0, l0, v1, r1, l1;
    logic [4:0] c0, c1;
    logic       rsp_valid, rsp_ready, rsp_tdo, rsp_id;
    logic       tck, tms, tdi, trst, srst, blink, tdo;
    logic [1:0] owner;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    jtag_bitbang_sched #(.FIFO_DEPTH(4), .HOLD_CYCLES(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .req0_valid_i (v0),
        .req0_ready_o (r0),
        .req0_cmd_i   (c0),
        .req0_lock_i  (l0),
        .req1_valid_i (v1),
        .req1_ready_o (r1),
        .req1_cmd_i   (c1),
        .req1_lock_i  (l1),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_tdo_o    (rsp_tdo),
        .rsp_id_o     (rsp_id),
        .jtag_tck_o   (tck),
        .jtag_tms_o   (tms),
        .jtag_tdi_o   (tdi),
        .jtag_trst_o  (trst),
        .jtag_srst_o  (srst),
        .blink_o      (blink),
        .jtag_tdo_i   (tdo),
        .owner_o      (owner)
    );

    function automatic logic [7:0] pins();
        return {2'b00, tck, tms, tdi, trst, srst, blink};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; rsp_ready = 1'b0; tdo = 1'b0;
        v0 = 0; l0 = 0; c0 = '0; v1 = 0; l1 = 0; c1 = '0;
        tick(2);
        chk("rst_pins", pins(), 8'h00);
        chk("rst_owner", {6'd0, owner}, 8'h00);
        chk("rst_rsp", {5'd0, rsp_valid, rsp_tdo, rsp_id}, 8'h00);
        rst_n = 1'b1;

        // WRITE pacing
        v0 = 1; l0 = 1; c0 = 5'b00_110;
        tick();
        chk("w_grant", {6'd0, owner}, 8'h01);
        chk("w_ready", {7'd0, r0}, 8'h01);
        tick();
        c0 = 5'b00_000;
        chk("w_nochange", pins(), 8'h00);
        tick();
        v0 = 0; l0 = 0;
        chk("w1_pins", pins(), 8'h30);
        tick();
        chk("w1_hold_a", pins(), 8'h30);
        chk("w_release", {6'd0, owner}, 8'h00);
        tick();
        chk("w1_hold_b", pins(), 8'h30);
        tick();
        chk("w2_pins", pins(), 8'h00);

        // READ response
        tdo = 1; v1 = 1; l1 = 1; c1 = 5'b11_000;
        tick();
        chk("r_grant", {6'd0, owner}, 8'h02);
        chk("r_ready", {7'd0, r1}, 8'h01);
        tick();
        v1 = 0; l1 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tdo = 0;
            chk("r_rsp_hold", {5'd0, rsp_valid, rsp_tdo, rsp_id}, 8'h07);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("r_rsp_clear", {7'd0, rsp_valid}, 8'h00);

        // Round-robin arbitration
        v0 = 1; v1 = 1; c0 = 5'b10_001; c1 = 5'b10_000;
        tick();
        chk("rr_p0", {6'd0, owner}, 8'h01);
        chk("rr_p1_blocked", {7'd0, r1}, 8'h00);
        tick();
        v0 = 0;
        tick();
        chk("rr_idle", {6'd0, owner}, 8'h00);
        chk("rr_blink1", pins(), 8'h01);
        tick();
        chk("rr_p1", {6'd0, owner}, 8'h02);
        tick();
        v1 = 0; v0 = 1;
        tick();
        v1 = 1;
        chk("rr_idle2", {6'd0, owner}, 8'h00);
        chk("rr_blink0", pins(), 8'h00);
        tick();
        chk("rr_back_p0", {6'd0, owner}, 8'h01);

        // Lock held with valid low
        v0 = 0; l0 = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("lock_owner_rdy1", {5'd0, r1, owner}, 8'h01);
        end
        l0 = 0; v1 = 0;
        tick();
        chk("lock_release", {6'd0, owner}, 8'h00);

        // FIFO fill with executor frozen, then drain
        enable = 0; v0 = 1; l0 = 1; c0 = 5'b00_111;
        tick();
        chk("f_ready", {7'd0, r0}, 8'h01);
        tick(); c0 = 5'b01_011;
        tick(); c0 = 5'b10_001;
        tick(); c0 = 5'b00_010;
        tick(); c0 = 5'b00_101;
        chk("f_full", {7'd0, r0}, 8'h00);
        tick();
        chk("f_full2", {7'd0, r0}, 8'h00);
        chk("f_frozen", pins(), 8'h00);
        tick();
        v0 = 0; l0 = 0; enable = 1;
        tick();
        chk("d_c0", pins(), 8'h38);
        tick(2);
        chk("d_c0_hold", pins(), 8'h38);
        tick();
        chk("d_c1", pins(), 8'h3E);
        tick();
        chk("d_c2", pins(), 8'h3F);
        tick();
        chk("d_c3", pins(), 8'h17);
        tick(3);
        chk("d_no_c4", pins(), 8'h17);

        // Reset during HOLD with entries queued
        enable = 0; v0 = 1; l0 = 1; c0 = 5'b00_101;
        tick();
        tick(); c0 = 5'b00_010;
        tick(); c0 = 5'b10_000;
        tick(); c0 = 5'b01_000;
        tick();
        v0 = 0; enable = 1;
        tick();
        chk("x_pop_a", pins(), 8'h2F);
        chk("x_owner", {6'd0, owner}, 8'h01);
        #2 rst_n = 0;
        #1;
        chk("x_rst_pins", pins(), 8'h00);
        chk("x_rst_owner", {6'd0, owner}, 8'h00);
        chk("x_rst_rsp", {5'd0, rsp_valid, rsp_tdo, rsp_id}, 8'h00);
        l0 = 0;
        tick(2);
        rst_n = 1;
        tick(6);
        chk("x_no_residual", pins(), 8'h00);
        chk("x_owner_idle", {6'd0, owner}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
